// File: rtl/dllp_rx_vc_handler.sv
// dllp_rx_vc_handler
//   Receives DLLPs from the PHY RX AXIS stream, checks the 16-bit DLLP CRC
//   and decodes Ack/Nak and flow-control DLLPs. Tracks InitFC1/InitFC2/UpdateFC
//   credits (P, NP, Cpl) for NUM_VC virtual channels, and counts bad-CRC and
//   unsupported-VC DLLPs in saturating counters.
//
//   A DLLP is two beats with tuser[0]=1: beat A carries the 4-byte body
//   (byte0 = tdata[7:0]), beat B carries the CRC in tdata[15:0].
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   phy_link_up_i           PHY link up; low = DL_Down
//   s_axis_*                PHY RX AXIS input (tkeep/tlast not used)
//   seq_num_o/_vld_o        Ack/Nak sequence number and 1-cycle valid pulse
//   seq_num_acknack_o       1 = Ack, 0 = Nak, qualified by seq_num_vld_o
//   fc1/fc2_values_stored_o per VC: InitFC1 / InitFC2 P, NP and Cpl all seen
//   tx_fc_*_o               raw credit values, VC n at [8n+:8] / [12n+:12]
//   crc_err_cnt_o           DLLPs dropped for bad CRC (saturating)
//   vc_err_cnt_o            FC DLLPs dropped for VC >= NUM_VC (saturating)
module dllp_rx_vc_handler #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int USER_WIDTH = 4,
    parameter int NUM_VC     = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    phy_link_up_i,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic                    s_axis_tready,
    output logic [11:0]             seq_num_o,
    output logic                    seq_num_vld_o,
    output logic                    seq_num_acknack_o,
    output logic [NUM_VC-1:0]       fc1_values_stored_o,
    output logic [NUM_VC-1:0]       fc2_values_stored_o,
    output logic [NUM_VC*8-1:0]     tx_fc_ph_o,
    output logic [NUM_VC*12-1:0]    tx_fc_pd_o,
    output logic [NUM_VC*8-1:0]     tx_fc_nph_o,
    output logic [NUM_VC*12-1:0]    tx_fc_npd_o,
    output logic [NUM_VC*8-1:0]     tx_fc_ch_o,
    output logic [NUM_VC*12-1:0]    tx_fc_cd_o,
    output logic [ERR_CNT_W-1:0]    crc_err_cnt_o,
    output logic [ERR_CNT_W-1:0]    vc_err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK_CRC = 2'd1,
        ST_PROCESS   = 2'd2
    } state_t;

    // DLLP CRC: poly 16'h100B, processed byte0 first, LSB first within a byte.
    function automatic logic [15:0] f_dllp_crc(input logic [15:0] crc_in,
                                               input logic [31:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 32; i++) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // 2-deep skid buffer (output register + temp register)
    // ------------------------------------------------------------------
    logic                  r_s_ready;
    logic                  r_m_valid;
    logic                  r_t_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [DATA_WIDTH-1:0] r_t_data;
    logic                  r_m_dllp;
    logic                  r_t_dllp;

    logic w_fsm_ready;
    logic w_m_valid_next;
    logic w_t_valid_next;
    logic w_in_to_out;
    logic w_in_to_tmp;
    logic w_tmp_to_out;
    logic w_s_ready_early;

    // Ready is registered, so it is computed one cycle early; the temp slot
    // catches the beat that arrives while the FSM is stalled.
    assign w_s_ready_early = w_fsm_ready || (!r_t_valid && (!r_m_valid || !s_axis_tvalid));

    always_comb begin
        w_m_valid_next = r_m_valid;
        w_t_valid_next = r_t_valid;
        w_in_to_out    = 1'b0;
        w_in_to_tmp    = 1'b0;
        w_tmp_to_out   = 1'b0;
        if (r_s_ready) begin
            if (w_fsm_ready || !r_m_valid) begin
                w_m_valid_next = s_axis_tvalid;
                w_in_to_out    = 1'b1;
            end else begin
                w_t_valid_next = s_axis_tvalid;
                w_in_to_tmp    = 1'b1;
            end
        end else if (w_fsm_ready) begin
            w_m_valid_next = r_t_valid;
            w_t_valid_next = 1'b0;
            w_tmp_to_out   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_t_valid <= 1'b0;
        end else begin
            r_s_ready <= w_s_ready_early;
            r_m_valid <= w_m_valid_next;
            r_t_valid <= w_t_valid_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_in_to_out) begin
            r_m_data <= s_axis_tdata;
            r_m_dllp <= s_axis_tuser[0];
        end else if (w_tmp_to_out) begin
            r_m_data <= r_t_data;
            r_m_dllp <= r_t_dllp;
        end
        if (w_in_to_tmp) begin
            r_t_data <= s_axis_tdata;
            r_t_dllp <= s_axis_tuser[0];
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and DLLP decode
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [31:0]           r_body;
    logic [15:0]           r_crc;
    logic [11:0]           r_seq;
    logic                  r_seq_vld;
    logic                  r_acknack;
    logic [NUM_VC*3-1:0]   r_fc1_seen;
    logic [NUM_VC*3-1:0]   r_fc2_seen;
    logic [NUM_VC*8-1:0]   r_ph;
    logic [NUM_VC*12-1:0]  r_pd;
    logic [NUM_VC*8-1:0]   r_nph;
    logic [NUM_VC*12-1:0]  r_npd;
    logic [NUM_VC*8-1:0]   r_ch;
    logic [NUM_VC*12-1:0]  r_cd;
    logic [ERR_CNT_W-1:0]  r_crc_err_cnt;
    logic [ERR_CNT_W-1:0]  r_vc_err_cnt;

    logic        w_accept;
    logic        w_crc_ok;
    logic [15:0] w_crc_calc;
    logic [2:0]  w_vc;
    logic [7:0]  w_hdr;
    logic [11:0] w_dat;
    logic        w_is_ack;
    logic        w_is_nak;
    logic [1:0]  w_fc_grp;
    logic [1:0]  w_fc_kind;
    logic        w_is_fc;
    logic        w_vc_bad;
    logic        w_unused;

    always_comb begin
        w_fsm_ready = 1'b0;
        case (r_state)
            ST_IDLE:      w_fsm_ready = phy_link_up_i;
            ST_CHECK_CRC: w_fsm_ready = 1'b1;
            default:      w_fsm_ready = 1'b0;
        endcase
    end

    assign w_accept   = r_m_valid && w_fsm_ready;
    assign w_crc_calc = f_dllp_crc(16'hFFFF, r_m_data);
    assign w_crc_ok   = (r_m_data[15:0] == r_crc);

    assign w_vc      = r_body[2:0];
    assign w_hdr     = {r_body[13:8], r_body[23:22]};
    assign w_dat     = {r_body[19:16], r_body[31:24]};
    assign w_is_ack  = (r_body[7:0] == 8'h00);
    assign w_is_nak  = (r_body[7:0] == 8'h10);
    // b0[7:6]: 01 InitFC1, 11 InitFC2, 10 UpdateFC; b0[5:4]: 0 P, 1 NP, 2 Cpl
    assign w_fc_grp  = r_body[7:6];
    assign w_fc_kind = r_body[5:4];
    assign w_is_fc   = !r_body[3] && (w_fc_grp != 2'b00) && (w_fc_kind != 2'b11);
    assign w_vc_bad  = (32'(w_vc) >= NUM_VC);

    assign w_unused = ^{s_axis_tkeep, s_axis_tlast, s_axis_tuser, r_body[15:14], r_body[21:20]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_body        <= '0;
            r_crc         <= '0;
            r_seq         <= '0;
            r_seq_vld     <= 1'b0;
            r_acknack     <= 1'b0;
            r_fc1_seen    <= '0;
            r_fc2_seen    <= '0;
            r_ph          <= '0;
            r_pd          <= '0;
            r_nph         <= '0;
            r_npd         <= '0;
            r_ch          <= '0;
            r_cd          <= '0;
            r_crc_err_cnt <= '0;
            r_vc_err_cnt  <= '0;
        end else begin
            r_seq_vld <= 1'b0;
            r_seq     <= '0;
            r_acknack <= 1'b0;
            if (!phy_link_up_i) begin
                // DL_Down: abandon any DLLP in flight; credits and counters hold.
                r_state    <= ST_IDLE;
                r_fc1_seen <= '0;
                r_fc2_seen <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && r_m_dllp) begin
                            r_body  <= r_m_data;
                            r_crc   <= w_crc_calc;
                            r_state <= ST_CHECK_CRC;
                        end
                    end
                    ST_CHECK_CRC: begin
                        if (w_accept) begin
                            if (!r_m_dllp) begin
                                r_state <= ST_IDLE;
                            end else if (w_crc_ok) begin
                                r_state <= ST_PROCESS;
                            end else begin
                                r_state <= ST_IDLE;
                                if (r_crc_err_cnt != '1) r_crc_err_cnt <= r_crc_err_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PROCESS: begin
                        r_state <= ST_IDLE;
                        if (w_is_ack || w_is_nak) begin
                            r_seq_vld <= 1'b1;
                            r_seq     <= w_dat;
                            r_acknack <= w_is_ack;
                        end else if (w_is_fc) begin
                            if (w_vc_bad) begin
                                if (r_vc_err_cnt != '1) r_vc_err_cnt <= r_vc_err_cnt + 1'b1;
                            end else begin
                                for (int unsigned v = 0; v < NUM_VC; v++) begin
                                    if (32'(w_vc) == v) begin
                                        case (w_fc_kind)
                                            2'd0: begin
                                                r_ph[v*8 +: 8]   <= w_hdr;
                                                r_pd[v*12 +: 12] <= w_dat;
                                            end
                                            2'd1: begin
                                                r_nph[v*8 +: 8]   <= w_hdr;
                                                r_npd[v*12 +: 12] <= w_dat;
                                            end
                                            default: begin
                                                r_ch[v*8 +: 8]   <= w_hdr;
                                                r_cd[v*12 +: 12] <= w_dat;
                                            end
                                        endcase
                                        if (w_fc_grp == 2'b01) r_fc1_seen[v*3 + 32'(w_fc_kind)] <= 1'b1;
                                        if (w_fc_grp == 2'b11) r_fc2_seen[v*3 + 32'(w_fc_kind)] <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        fc1_values_stored_o = '0;
        fc2_values_stored_o = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            fc1_values_stored_o[v] = &r_fc1_seen[v*3 +: 3];
            fc2_values_stored_o[v] = &r_fc2_seen[v*3 +: 3];
        end
    end

    assign s_axis_tready     = r_s_ready;
    assign seq_num_o         = r_seq;
    assign seq_num_vld_o     = r_seq_vld;
    assign seq_num_acknack_o = r_acknack;
    assign tx_fc_ph_o        = r_ph;
    assign tx_fc_pd_o        = r_pd;
    assign tx_fc_nph_o       = r_nph;
    assign tx_fc_npd_o       = r_npd;
    assign tx_fc_ch_o        = r_ch;
    assign tx_fc_cd_o        = r_cd;
    assign crc_err_cnt_o     = r_crc_err_cnt;
    assign vc_err_cnt_o      = r_vc_err_cnt;

endmodule

// File: tb/tb_dllp_rx_vc_handler.sv
// tb_dllp_rx_vc_handler
//   Directed self-checking bench for dllp_rx_vc_handler with NUM_VC=2,
//   ERR_CNT_W=8. DLLP bodies and CRCs are built by the bench itself.
module tb_dllp_rx_vc_handler;

    localparam int NVC = 2;
    localparam int EW  = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            phy_link_up_i;
    logic [31:0]     s_axis_tdata;
    logic [3:0]      s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic [3:0]      s_axis_tuser;
    logic            s_axis_tready;
    logic [11:0]     seq_num_o;
    logic            seq_num_vld_o;
    logic            seq_num_acknack_o;
    logic [NVC-1:0]  fc1_values_stored_o;
    logic [NVC-1:0]  fc2_values_stored_o;
    logic [NVC*8-1:0]  tx_fc_ph_o;
    logic [NVC*12-1:0] tx_fc_pd_o;
    logic [NVC*8-1:0]  tx_fc_nph_o;
    logic [NVC*12-1:0] tx_fc_npd_o;
    logic [NVC*8-1:0]  tx_fc_ch_o;
    logic [NVC*12-1:0] tx_fc_cd_o;
    logic [EW-1:0]   crc_err_cnt_o;
    logic [EW-1:0]   vc_err_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dllp_rx_vc_handler #(
        .DATA_WIDTH(32),
        .KEEP_WIDTH(4),
        .USER_WIDTH(4),
        .NUM_VC    (NVC),
        .ERR_CNT_W (EW)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .phy_link_up_i      (phy_link_up_i),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tready      (s_axis_tready),
        .seq_num_o          (seq_num_o),
        .seq_num_vld_o      (seq_num_vld_o),
        .seq_num_acknack_o  (seq_num_acknack_o),
        .fc1_values_stored_o(fc1_values_stored_o),
        .fc2_values_stored_o(fc2_values_stored_o),
        .tx_fc_ph_o         (tx_fc_ph_o),
        .tx_fc_pd_o         (tx_fc_pd_o),
        .tx_fc_nph_o        (tx_fc_nph_o),
        .tx_fc_npd_o        (tx_fc_npd_o),
        .tx_fc_ch_o         (tx_fc_ch_o),
        .tx_fc_cd_o         (tx_fc_cd_o),
        .crc_err_cnt_o      (crc_err_cnt_o),
        .vc_err_cnt_o       (vc_err_cnt_o)
    );

    // Ack/Nak monitor: captures every valid pulse and the longest pulse run.
    int          vcnt   = 0;
    int          run    = 0;
    int          maxrun = 0;
    logic [11:0] cap_seq [32];
    logic        cap_ack [32];

    always @(negedge clk_i) begin
        if (seq_num_vld_o) begin
            cap_seq[vcnt % 32] <= seq_num_o;
            cap_ack[vcnt % 32] <= seq_num_acknack_o;
            vcnt <= vcnt + 1;
            run  <= run + 1;
            if (run + 1 > maxrun) maxrun <= run + 1;
        end else begin
            run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: byte0 first, each byte LSB first, poly 16'h100B, seed all-ones.
    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            b = d[8*k +: 8];
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ b[j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h100B;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] fc_body(input logic [3:0] t, input logic [2:0] vc,
                                            input logic [7:0] hdr, input logic [11:0] dat);
        logic [7:0] b0, b1, b2, b3;
        b0 = {t, 1'b0, vc};
        b1 = {2'b00, hdr[7:2]};
        b2 = {hdr[1:0], 2'b00, dat[11:8]};
        b3 = dat[7:0];
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [31:0] an_body(input logic [7:0] t, input logic [11:0] s);
        return {s[7:0], 4'h0, s[11:8], 8'h00, t};
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic put_beat(input logic [31:0] d, input logic dl, input logic last);
        int n;
        s_axis_tdata  = d;
        s_axis_tuser  = {3'b000, dl};
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL handshake_timeout observed=%0d expected<100", n);
        end
        @(negedge clk_i);
    endtask

    task automatic send_dllp(input logic [31:0] body, input logic [15:0] crc_flip, input logic hold);
        put_beat(body, 1'b1, 1'b0);
        put_beat({16'h0000, crc16(body) ^ crc_flip}, 1'b1, 1'b1);
        if (!hold) s_axis_tvalid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Exact Ack/Nak timing: pulse one cycle after the FSM takes beat B.
    task automatic chk_acknak(input string tag, input logic [11:0] s, input logic a);
        @(negedge clk_i);
        check({tag, "_early"}, 32'(seq_num_vld_o), 0);
        @(negedge clk_i);
        check({tag, "_vld"}, 32'(seq_num_vld_o), 1);
        check({tag, "_seq"}, 32'(seq_num_o), 32'(s));
        check({tag, "_an"}, 32'(seq_num_acknack_o), 32'(a));
        @(negedge clk_i);
        check({tag, "_vld_off"}, 32'(seq_num_vld_o), 0);
        check({tag, "_seq_off"}, 32'(seq_num_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    logic [11:0] exp_seq [4];
    logic        exp_ack [4];
    int          vbase;

    initial begin
        rst_i         = 1'b1;
        phy_link_up_i = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        settle(3);

        // Reset state
        check("rst_tready", 32'(s_axis_tready), 0);
        check("rst_ph", 32'(tx_fc_ph_o), 0);
        check("rst_cd", 32'(tx_fc_cd_o), 0);
        check("rst_vld", 32'(seq_num_vld_o), 0);
        check("rst_fc1", 32'(fc1_values_stored_o), 0);
        check("rst_crc_err", 32'(crc_err_cnt_o), 0);
        check("rst_vc_err", 32'(vc_err_cnt_o), 0);
        rst_i = 1'b0;
        settle(2);
        check("tready_up", 32'(s_axis_tready), 1);

        // InitFC1 P VC0: exact update latency
        send_dllp(fc_body(4'h4, 3'd0, 8'h20, 12'h100), 16'h0000, 1'b0);
        @(negedge clk_i);
        check("fc1p_early", 32'(tx_fc_ph_o[7:0]), 0);
        @(negedge clk_i);
        check("fc1p_ph", 32'(tx_fc_ph_o[7:0]), 32'h20);
        check("fc1p_pd", 32'(tx_fc_pd_o[11:0]), 32'h100);
        check("fc1p_flag", 32'(fc1_values_stored_o), 0);
        settle(2);

        send_dllp(fc_body(4'h5, 3'd0, 8'h33, 12'h2AA), 16'h0000, 1'b0);
        settle(4);
        check("fc1np_nph", 32'(tx_fc_nph_o[7:0]), 32'h33);
        check("fc1np_npd", 32'(tx_fc_npd_o[11:0]), 32'h2AA);
        check("fc1np_flag", 32'(fc1_values_stored_o), 0);

        send_dllp(fc_body(4'h6, 3'd0, 8'h44, 12'h055), 16'h0000, 1'b0);
        settle(4);
        check("fc1cpl_ch", 32'(tx_fc_ch_o[7:0]), 32'h44);
        check("fc1cpl_cd", 32'(tx_fc_cd_o[11:0]), 32'h055);
        check("fc1_all_flag", 32'(fc1_values_stored_o), 32'h1);
        check("fc2_flag_none", 32'(fc2_values_stored_o), 0);

        // Ack / Nak
        send_dllp(an_body(8'h00, 12'hABC), 16'h0000, 1'b0);
        chk_acknak("ack", 12'hABC, 1'b1);
        settle(2);
        send_dllp(an_body(8'h10, 12'h005), 16'h0000, 1'b0);
        chk_acknak("nak", 12'h005, 1'b0);
        settle(2);

        // Corrupt CRC on UpdateFC P: dropped and counted
        send_dllp(fc_body(4'h8, 3'd0, 8'h55, 12'h3FF), 16'h0001, 1'b0);
        settle(4);
        check("badcrc_ph", 32'(tx_fc_ph_o[7:0]), 32'h20);
        check("badcrc_pd", 32'(tx_fc_pd_o[11:0]), 32'h100);
        check("badcrc_cnt", 32'(crc_err_cnt_o), 1);

        send_dllp(fc_body(4'h8, 3'd0, 8'h21, 12'h101), 16'h0000, 1'b0);
        settle(4);
        check("updp_ph", 32'(tx_fc_ph_o[7:0]), 32'h21);
        check("updp_pd", 32'(tx_fc_pd_o[11:0]), 32'h101);
        check("updp_cnt", 32'(crc_err_cnt_o), 1);

        // 300 more bad CRCs: counter saturates
        for (int i = 0; i < 300; i++)
            send_dllp(fc_body(4'h8, 3'd0, 8'h55, 12'h3FF), 16'h8000, 1'b0);
        settle(4);
        check("crc_sat", 32'(crc_err_cnt_o), 32'hFF);
        check("crc_sat_ph", 32'(tx_fc_ph_o[7:0]), 32'h21);

        // InitFC2 Cpl on VC1, then on unsupported VC3
        send_dllp(fc_body(4'hE, 3'd1, 8'h10, 12'h040), 16'h0000, 1'b0);
        settle(4);
        check("vc1_ch", 32'(tx_fc_ch_o), 32'h1044);
        check("vc1_cd", 32'(tx_fc_cd_o), 32'h040055);
        check("vc1_fc2", 32'(fc2_values_stored_o), 0);
        check("vc1_vcerr", 32'(vc_err_cnt_o), 0);

        send_dllp(fc_body(4'hE, 3'd3, 8'h77, 12'h777), 16'h0000, 1'b0);
        settle(4);
        check("vc3_ch", 32'(tx_fc_ch_o), 32'h1044);
        check("vc3_cd", 32'(tx_fc_cd_o), 32'h040055);
        check("vc3_vcerr", 32'(vc_err_cnt_o), 1);

        // Link drop between beat A and beat B
        put_beat(fc_body(4'h4, 3'd0, 8'h99, 12'h999), 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        settle(2);
        phy_link_up_i = 1'b0;
        settle(3);
        check("ld_fc1", 32'(fc1_values_stored_o), 0);
        check("ld_ph", 32'(tx_fc_ph_o[7:0]), 32'h21);
        phy_link_up_i = 1'b1;
        settle(2);
        send_dllp(fc_body(4'h9, 3'd0, 8'h66, 12'h666), 16'h0000, 1'b0);
        settle(4);
        check("lu_nph", 32'(tx_fc_nph_o[7:0]), 32'h66);
        check("lu_npd", 32'(tx_fc_npd_o[11:0]), 32'h666);
        check("lu_ph", 32'(tx_fc_ph_o[7:0]), 32'h21);
        check("lu_pd", 32'(tx_fc_pd_o[11:0]), 32'h101);

        // Back-to-back stream, tvalid held high throughout
        exp_seq = '{12'h100, 12'h201, 12'h302, 12'h403};
        exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
        vbase = vcnt;
        put_beat(32'hDEADBEEF, 1'b0, 1'b1);
        send_dllp(an_body(8'h00, 12'h100), 16'h0000, 1'b1);
        send_dllp(an_body(8'h10, 12'h201), 16'h0000, 1'b1);
        send_dllp(32'h00000030, 16'h0000, 1'b1);
        send_dllp(an_body(8'h00, 12'h302), 16'h0000, 1'b1);
        send_dllp(fc_body(4'h8, 3'd1, 8'hA5, 12'h5A5), 16'h0000, 1'b1);
        send_dllp(an_body(8'h10, 12'h403), 16'h0000, 1'b1);
        s_axis_tvalid = 1'b0;
        settle(8);
        check("b2b_count", 32'(vcnt - vbase), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_seq%0d", k), 32'(cap_seq[(vbase + k) % 32]), 32'(exp_seq[k]));
            check($sformatf("b2b_an%0d", k), 32'(cap_ack[(vbase + k) % 32]), 32'(exp_ack[k]));
        end
        check("b2b_ph", 32'(tx_fc_ph_o), 32'hA521);
        check("b2b_pd", 32'(tx_fc_pd_o), 32'h5A5101);
        check("vld_width", 32'(maxrun), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
